argo_chan_fifo: RTL and testbench

Buffered channel stage that sits directly downstream of argo_3stage and absorbs its dataout/ovalid stream. It models an Argo go-routine channel with a fixed capacity and decouples the pipeline from a stalling consumer. It is first-word-fall-through and uses the same valid/ready handshake as argo_3stage. It also exposes occupancy and stall statistics for benches.

---
 rtl/argo_chan_fifo.sv | 112 +++++++++++
 tb/tb_argo_chan_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/argo_chan_fifo.sv
// rtl/argo_chan_fifo.sv - first-word-fall-through channel FIFO with occupancy and stall statistics
// Buffers the argo_3stage output stream and decouples it from a stalling consumer.
module argo_chan_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ivalid,
  output logic               oready,
  input  logic [WIDTH-1:0]   datain,
  output logic               ovalid,
  input  logic               iready,
  output logic [WIDTH-1:0]   dataout,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               empty,
  output logic [ADDR_W:0]    max_count,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam logic [ADDR_W:0]    CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]    CNT_LAST  = (ADDR_W+1)'(DEPTH-1);
  localparam logic [ADDR_W-1:0]  PTR_ONE   = ADDR_W'(1);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W:0]    r_max_count;
  logic [STALL_W-1:0] r_stall_cnt;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W:0]    w_count_nxt;
  logic               w_push;
  logic               w_pop;

  assign full      = (r_state == ST_FULL);
  assign empty     = (r_state == ST_EMPTY);
  assign oready    = rst && !full;
  assign ovalid    = !empty;
  assign w_push    = ivalid && oready;
  assign w_pop     = ovalid && iready;
  // Gate on empty so the unreset memory never leaks X onto the output.
  assign dataout   = empty ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;
  assign max_count = r_max_count;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_nxt = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (w_push && !w_pop && r_count == CNT_LAST) begin
          w_state_nxt = ST_FULL;
        end else if (w_pop && !w_push && r_count == CNT_ONE) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) w_state_nxt = ST_PARTIAL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_max_count <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_count_nxt > r_max_count) r_max_count <= w_count_nxt;
      if (ivalid && !oready && r_stall_cnt != '1) begin
        r_stall_cnt <= r_stall_cnt + STALL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= datain;
  end

endmodule

// File: tb/tb_argo_chan_fifo.sv
// tb/tb_argo_chan_fifo.sv - directed self-checking bench for argo_chan_fifo
// Inputs change 1ns after posedge; outputs are sampled mid-cycle.
module tb_argo_chan_fifo;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int STALL_W = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               ivalid;
  logic               oready;
  logic [WIDTH-1:0]   datain;
  logic               ovalid;
  logic               iready;
  logic [WIDTH-1:0]   dataout;
  logic [ADDR_W:0]    count;
  logic               full;
  logic               empty;
  logic [ADDR_W:0]    max_count;
  logic [STALL_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  argo_chan_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STALL_W(STALL_W)
  ) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .oready(oready), .datain(datain),
    .ovalid(ovalid), .iready(iready), .dataout(dataout), .count(count),
    .full(full), .empty(empty), .max_count(max_count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int i;
    logic acc;

    rst = 1'b0; ivalid = 1'b0; iready = 1'b0; datain = '0;
    #1;
    check_eq("rst_oready", oready, 0);
    check_eq("rst_ovalid", ovalid, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_dataout", dataout, 0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check_eq("idle_oready", oready, 1);
    check_eq("idle_ovalid", ovalid, 0);
    check_eq("idle_empty", empty, 1);
    check_eq("idle_count", count, 0);
    check_eq("idle_dataout", dataout, 0);
    check_eq("idle_stall", stall_cnt, 0);
    check_eq("idle_max", max_count, 0);

    // single word
    tick();
    ivalid = 1'b1; datain = 32'h25; iready = 1'b1;
    #1;
    check_eq("single_no_bypass", ovalid, 0);
    tick();
    ivalid = 1'b0;
    check_eq("single_ovalid", ovalid, 1);
    check_eq("single_data", dataout, 32'h25);
    check_eq("single_count", count, 1);
    tick();
    check_eq("single_empty", empty, 1);
    check_eq("single_ovalid_off", ovalid, 0);
    check_eq("single_max", max_count, 1);

    // fill, stall, drain
    iready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      ivalid = 1'b1; datain = 32'h10 + j;
      tick();
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_oready", oready, 0);
    check_eq("fill_count", count, 8);
    check_eq("fill_max", max_count, 8);
    datain = 32'h18;
    tick(); tick(); tick();
    check_eq("fill_stall3", stall_cnt, 3);
    check_eq("fill_hold_count", count, 8);
    check_eq("fill_head", dataout, 32'h10);
    iready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 30 && k < 9; cyc++) begin
      if (ovalid) begin
        check_eq($sformatf("drain_%0d", k), dataout, 32'h10 + k);
        k++;
      end
      acc = ivalid && oready;
      tick();
      if (acc) ivalid = 1'b0;
    end
    check_eq("drain_words", k, 9);
    check_eq("drain_stall", stall_cnt, 4);
    check_eq("drain_empty", empty, 1);

    // streaming with pointer wrap
    i = 0; k = 0;
    for (int cyc = 0; cyc < 40 && k < 20; cyc++) begin
      if (i < 20) begin ivalid = 1'b1; datain = 32'h100 + i; end
      else ivalid = 1'b0;
      #1;
      check_eq("stream_count_le1", count <= 1, 1);
      if (ovalid) begin
        check_eq($sformatf("stream_%0d", k), dataout, 32'h100 + k);
        k++;
      end
      acc = ivalid && oready;
      tick();
      if (acc) i++;
    end
    ivalid = 1'b0;
    check_eq("stream_words", k, 20);
    check_eq("stream_max", max_count, 8);

    // simultaneous push/pop at count 4
    iready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      ivalid = 1'b1; datain = 32'h200 + j;
      tick();
    end
    check_eq("sim_count_pre", count, 4);
    iready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      datain = 32'h204 + j;
      #1;
      check_eq($sformatf("sim_data_%0d", j), dataout, 32'h200 + j);
      tick();
      check_eq($sformatf("sim_count_%0d", j), count, 4);
    end
    ivalid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("sim_tail_%0d", j), dataout, 32'h20a + j);
      tick();
    end
    check_eq("sim_empty", empty, 1);

    // asynchronous reset mid-operation
    iready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      ivalid = 1'b1; datain = 32'h300 + j;
      tick();
    end
    ivalid = 1'b0;
    check_eq("arst_count_pre", count, 5);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_ovalid", ovalid, 0);
    check_eq("arst_oready", oready, 0);
    check_eq("arst_max", max_count, 0);
    tick();
    rst = 1'b1;
    ivalid = 1'b1; datain = 32'h55;
    tick();
    ivalid = 1'b0;
    check_eq("arst_post_ovalid", ovalid, 1);
    check_eq("arst_post_data", dataout, 32'h55);
    check_eq("arst_post_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
